// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit_pkg
// Purpose  : Shared definitions for the instruction-fetch stage: FSM state
//            encodings and the default datapath width / reset PC.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package fetch_unit_pkg;

    // Fetch FSM state encodings
    localparam logic [1:0] c_st_req  = 2'd0;
    localparam logic [1:0] c_st_wait = 2'd1;
    localparam logic [1:0] c_st_hold = 2'd2;

    // Datapath defaults
    localparam int          c_width_default    = 16;
    localparam logic [15:0] c_reset_pc_default = 16'h3000;

endpackage : fetch_unit_pkg
`default_nettype wire

// File: rtl/fetch_unit_pc_register.sv
`default_nettype none
// ============================================================================
// Module   : pc_register
// Purpose  : WIDTH-bit program counter with synchronous reset to RESET_PC,
//            a load enable (pc_in) and an increment enable. Load wins over
//            increment. Increment wraps modulo 2^WIDTH.
// Ports    : clk      - clock
//            reset    - synchronous active-high reset
//            pc_in    - value to load
//            ld       - load pc_in
//            inc      - increment PC by one
//            pc_out   - current PC
//            pc_next  - value the PC takes at the next edge (reset aside)
// Revision : 1.0 - initial release
// ============================================================================
module pc_register
    import fetch_unit_pkg::*;
#(
    parameter int               WIDTH    = c_width_default,
    parameter logic [WIDTH-1:0] RESET_PC = c_reset_pc_default
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pc_in,
    input  logic             ld,
    input  logic             inc,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] pc_next
);

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] w_pc_next;

    always_comb begin
        w_pc_next = r_pc;
        if (ld) begin
            w_pc_next = pc_in;
        end else if (inc) begin
            w_pc_next = r_pc + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign pc_out  = r_pc;
    assign pc_next = w_pc_next;

endmodule : pc_register
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction-fetch stage around the PC select mux. Owns the PC,
//            runs a req/ready read handshake to instruction memory, latches
//            the fetched word into IR and supports PC redirect at any time,
//            squashing an in-flight fetch when needed.
// Ports    : clk, reset          - clock, synchronous active-high reset
//            pc_in, ld_pc        - redirect target and load strobe
//            pc_out              - current PC (mux next_instruction operand)
//            mem_addr, mem_req   - instruction memory read request
//            mem_ready, mem_rdata- memory accept / returned word
//            ir_out, ir_valid    - instruction register and its valid flag
//            ir_ack              - decode consumes ir_out
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int               WIDTH    = c_width_default,
    parameter logic [WIDTH-1:0] RESET_PC = c_reset_pc_default
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pc_in,
    input  logic             ld_pc,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] mem_addr,
    output logic             mem_req,
    input  logic             mem_ready,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic [WIDTH-1:0] ir_out,
    output logic             ir_valid,
    input  logic             ir_ack
);

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic             r_squash;
    logic             r_req_en;
    logic [WIDTH-1:0] r_req_addr;
    logic [WIDTH-1:0] r_ir;
    logic             r_ir_valid;

    logic [WIDTH-1:0] w_pc;
    logic [WIDTH-1:0] w_pc_next;
    logic             w_mem_req;
    logic             w_handshake;
    logic             w_capture;
    logic             w_set_squash;
    logic             w_pc_inc;
    logic             w_ir_drop;
    logic             w_req_addr_ld;

    pc_register #(
        .WIDTH    (WIDTH),
        .RESET_PC (RESET_PC)
    ) u_pc_register (
        .clk     (clk),
        .reset   (reset),
        .pc_in   (pc_in),
        .ld      (ld_pc),
        .inc     (w_pc_inc),
        .pc_out  (w_pc),
        .pc_next (w_pc_next)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_req;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_req, c_st_wait: begin
                if (w_handshake) begin
                    // A redirect this cycle or a pending squash throws the
                    // word away and refetches from the (new) PC.
                    w_state_next = (ld_pc || r_squash) ? c_st_req : c_st_hold;
                end else if (w_mem_req) begin
                    w_state_next = c_st_wait;
                end
            end
            c_st_hold: begin
                if (ir_ack || ld_pc) begin
                    w_state_next = c_st_req;
                end
            end
            default: w_state_next = c_st_req;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / control decode
    // ------------------------------------------------------------------
    always_comb begin
        w_mem_req    = 1'b0;
        w_pc_inc     = 1'b0;
        w_ir_drop    = 1'b0;
        case (r_state)
            // r_req_en keeps the request low for the first cycle after reset
            c_st_req, c_st_wait: w_mem_req = r_req_en;
            c_st_hold: begin
                w_pc_inc  = ir_ack;
                w_ir_drop = ir_ack || ld_pc;
            end
            default: w_mem_req = 1'b0;
        endcase
        w_handshake  = w_mem_req && mem_ready;
        w_capture    = w_handshake && !ld_pc && !r_squash;
        // Redirect while a request is still outstanding: the handshake must
        // complete, so remember to discard what comes back.
        w_set_squash = w_mem_req && ld_pc && !mem_ready;
    end

    // Every entry into REQ latches the PC value of that edge as the address.
    assign w_req_addr_ld = (w_state_next == c_st_req);

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_squash   <= 1'b0;
            r_req_en   <= 1'b0;
            r_req_addr <= RESET_PC;
            r_ir       <= '0;
            r_ir_valid <= 1'b0;
        end else begin
            r_req_en <= 1'b1;
            if (w_handshake) begin
                r_squash <= 1'b0;
            end else if (w_set_squash) begin
                r_squash <= 1'b1;
            end
            if (w_req_addr_ld) begin
                r_req_addr <= w_pc_next;
            end
            if (w_capture) begin
                r_ir <= mem_rdata;
            end
            if (w_capture) begin
                r_ir_valid <= 1'b1;
            end else if (w_ir_drop) begin
                r_ir_valid <= 1'b0;
            end
        end
    end

    assign pc_out   = w_pc;
    assign mem_addr = r_req_addr;
    assign mem_req  = w_mem_req;
    assign ir_out   = r_ir;
    assign ir_valid = r_ir_valid;

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Self-checking bench for fetch_unit: a table of per-cycle input
//            vectors with hand-computed post-edge outputs, followed by
//            hand-written sequences for HOLD stalls and reset mid-fetch.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    typedef struct {
        logic        rst;
        logic        ld;
        logic [15:0] pin;
        logic        rdy;
        logic [15:0] rdata;
        logic        ack;
        logic [15:0] e_pc;
        logic [15:0] e_addr;
        logic        e_req;
        logic [15:0] e_ir;
        logic        e_irv;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pc_in;
    logic        ld_pc;
    logic [15:0] pc_out;
    logic [15:0] mem_addr;
    logic        mem_req;
    logic        mem_ready;
    logic [15:0] mem_rdata;
    logic [15:0] ir_out;
    logic        ir_valid;
    logic        ir_ack;

    int n_checks = 0;
    int n_errors = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    fetch_unit #(
        .WIDTH    (16),
        .RESET_PC (16'h3000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pc_in     (pc_in),
        .ld_pc     (ld_pc),
        .pc_out    (pc_out),
        .mem_addr  (mem_addr),
        .mem_req   (mem_req),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .ir_out    (ir_out),
        .ir_valid  (ir_valid),
        .ir_ack    (ir_ack)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic rst, input logic ld, input logic [15:0] pin,
                       input logic rdy, input logic [15:0] rdata, input logic ack,
                       input logic [15:0] e_pc, input logic [15:0] e_addr,
                       input logic e_req, input logic [15:0] e_ir, input logic e_irv);
        vec_t v;
        v.rst = rst; v.ld = ld; v.pin = pin; v.rdy = rdy; v.rdata = rdata; v.ack = ack;
        v.e_pc = e_pc; v.e_addr = e_addr; v.e_req = e_req; v.e_ir = e_ir; v.e_irv = e_irv;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic rst, input logic ld, input logic [15:0] pin,
                         input logic rdy, input logic [15:0] rdata, input logic ack);
        reset = rst; ld_pc = ld; pc_in = pin; mem_ready = rdy; mem_rdata = rdata; ir_ack = ack;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_all(input string tag, input logic [15:0] e_pc, input logic [15:0] e_addr,
                              input logic e_req, input logic [15:0] e_ir, input logic e_irv);
        chk({tag, ".pc_out"},   pc_out,          e_pc);
        chk({tag, ".mem_addr"}, mem_addr,        e_addr);
        chk({tag, ".mem_req"},  {15'd0, mem_req},  {15'd0, e_req});
        chk({tag, ".ir_out"},   ir_out,          e_ir);
        chk({tag, ".ir_valid"}, {15'd0, ir_valid}, {15'd0, e_irv});
    endtask

    initial begin
        reset = 1'b1; ld_pc = 1'b0; pc_in = '0; mem_ready = 1'b0; mem_rdata = '0; ir_ack = 1'b0;

        //   rst ld pin      rdy rdata    ack   pc       addr     req ir       irv
        add(1, 0, 16'h0000, 0, 16'h0000, 0,   16'h3000,16'h3000, 0, 16'h0000,0); // reset state
        add(0, 0, 16'h0000, 1, 16'hAAAA, 0,   16'h3000,16'h3000, 1, 16'h0000,0); // request opens
        add(0, 0, 16'h0000, 1, 16'h1111, 1,   16'h3000,16'h3000, 0, 16'h1111,1); // fetch 3000
        add(0, 0, 16'h0000, 1, 16'h9999, 1,   16'h3001,16'h3001, 1, 16'h1111,0); // ack
        add(0, 0, 16'h0000, 1, 16'h2222, 1,   16'h3001,16'h3001, 0, 16'h2222,1); // fetch 3001
        add(0, 0, 16'h0000, 1, 16'h9999, 1,   16'h3002,16'h3002, 1, 16'h2222,0);
        add(0, 0, 16'h0000, 1, 16'h3333, 0,   16'h3002,16'h3002, 0, 16'h3333,1); // fetch 3002
        add(0, 0, 16'h0000, 0, 16'h9999, 1,   16'h3003,16'h3003, 1, 16'h3333,0);
        add(0, 0, 16'h0000, 0, 16'h9999, 0,   16'h3003,16'h3003, 1, 16'h3333,0); // WAIT
        add(0, 0, 16'h0000, 0, 16'h9999, 0,   16'h3003,16'h3003, 1, 16'h3333,0);
        add(0, 0, 16'h0000, 0, 16'h9999, 0,   16'h3003,16'h3003, 1, 16'h3333,0);
        add(0, 0, 16'h0000, 1, 16'h4444, 0,   16'h3003,16'h3003, 0, 16'h4444,1); // late ready
        add(0, 0, 16'h0000, 0, 16'h9999, 1,   16'h3004,16'h3004, 1, 16'h4444,0);
        add(0, 0, 16'h0000, 0, 16'h9999, 0,   16'h3004,16'h3004, 1, 16'h4444,0); // WAIT
        add(0, 1, 16'h4050, 0, 16'h9999, 0,   16'h4050,16'h3004, 1, 16'h4444,0); // redirect in WAIT
        add(0, 0, 16'h0000, 1, 16'hDEAD, 0,   16'h4050,16'h4050, 1, 16'h4444,0); // squashed
        add(0, 0, 16'h0000, 1, 16'h5555, 0,   16'h4050,16'h4050, 0, 16'h5555,1); // refetch 4050
        add(0, 0, 16'h0000, 0, 16'h9999, 1,   16'h4051,16'h4051, 1, 16'h5555,0);
        add(0, 1, 16'h0123, 1, 16'hBEEF, 0,   16'h0123,16'h0123, 1, 16'h5555,0); // redirect at handshake
        add(0, 0, 16'h0000, 1, 16'h6666, 0,   16'h0123,16'h0123, 0, 16'h6666,1);
        add(0, 1, 16'hFFFF, 0, 16'h9999, 0,   16'hFFFF,16'hFFFF, 1, 16'h6666,0); // redirect in HOLD
        add(0, 0, 16'h0000, 1, 16'h7777, 0,   16'hFFFF,16'hFFFF, 0, 16'h7777,1);
        add(0, 0, 16'h0000, 0, 16'h9999, 1,   16'h0000,16'h0000, 1, 16'h7777,0); // wrap
        add(0, 0, 16'h0000, 1, 16'h8888, 0,   16'h0000,16'h0000, 0, 16'h8888,1);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].ld, vecs[i].pin, vecs[i].rdy, vecs[i].rdata, vecs[i].ack);
            expect_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_addr,
                       vecs[i].e_req, vecs[i].e_ir, vecs[i].e_irv);
        end

        // HOLD with ir_ack withheld: everything stays put
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 16'h0000, 1, 16'hC0DE + 16'(i), 0);
            expect_all($sformatf("hold%0d", i), 16'h0000, 16'h0000, 0, 16'h8888, 1);
        end
        drive(0, 0, 16'h0000, 0, 16'h9999, 1);
        expect_all("hold_ack", 16'h0001, 16'h0001, 1, 16'h8888, 0);

        // Reset while in WAIT
        drive(0, 0, 16'h0000, 0, 16'h9999, 0);
        expect_all("pre_rst_wait", 16'h0001, 16'h0001, 1, 16'h8888, 0);
        drive(1, 0, 16'h0000, 0, 16'h9999, 0);
        expect_all("rst_wait", 16'h3000, 16'h3000, 0, 16'h0000, 0);
        drive(0, 0, 16'h0000, 0, 16'h9999, 0);
        expect_all("restart", 16'h3000, 16'h3000, 1, 16'h0000, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 16'h0000, 0, 16'h9999, 0);
            expect_all($sformatf("wait3000_%0d", i), 16'h3000, 16'h3000, 1, 16'h0000, 0);
        end
        drive(0, 0, 16'h0000, 1, 16'hABCD, 0);
        expect_all("fetch3000", 16'h3000, 16'h3000, 0, 16'hABCD, 1);

        // Reset while in HOLD
        drive(1, 0, 16'h0000, 1, 16'h9999, 0);
        expect_all("rst_hold", 16'h3000, 16'h3000, 0, 16'h0000, 0);
        drive(0, 0, 16'h0000, 1, 16'h9999, 0);
        expect_all("restart2", 16'h3000, 16'h3000, 1, 16'h0000, 0);
        drive(0, 0, 16'h0000, 1, 16'h1234, 0);
        expect_all("refetch3000", 16'h3000, 16'h3000, 0, 16'h1234, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_fetch_unit
`default_nettype wire
